// File: rtl/pc_next_if.sv
// Bundle between pc_next_unit and its neighbours: redirect inputs from decode and
// the imem req/gnt handshake. The slave modport is the PC unit's view of the bundle.
interface pc_next_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      j_addr;
  logic             jump;
  logic             jr;
  logic [31:0]      jr_addr;
  logic             br_taken;
  logic [31:0]      br_offset;
  logic             stall;
  logic             imem_gnt;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic [31:0]      pc;
  logic [31:0]      pc_4;
  logic             addr_err;
  logic [CNT_W-1:0] fetch_cnt;

  modport master (
    output j_addr, jump, jr, jr_addr, br_taken, br_offset, stall, imem_gnt,
    input  imem_req, imem_addr, pc, pc_4, addr_err, fetch_cnt
  );

  modport slave (
    input  j_addr, jump, jr, jr_addr, br_taken, br_offset, stall, imem_gnt,
    output imem_req, imem_addr, pc, pc_4, addr_err, fetch_cnt
  );
endinterface

// File: rtl/pc_next_unit.sv
// Owns the architectural PC: selects the next PC from jr/jump/branch redirects or
// pc+4, and fetches through a req/gnt handshake that keeps imem_addr stable until granted.
module pc_next_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input logic     clk,
  input logic     rst_n,
  pc_next_if.slave bus
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_addr_q, pend_addr_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_err_q, pend_err_d;
  logic             imem_req_q, imem_req_d;
  logic             addr_err_q, addr_err_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

  logic [31:0] pc_4;
  logic [31:0] br_target;
  logic [31:0] redir_raw;
  logic [31:0] redir_addr;
  logic        redir_mis;
  logic        redir_live;
  logic        accept;

  assign pc_4      = pc_q + 32'd4;
  assign br_target = pc_4 + (bus.br_offset << 2);
  assign accept    = (state_q == FETCH) && bus.imem_gnt && !bus.stall;
  // Redirects only count while the pipe is moving; a held stage's decode is stale.
  assign redir_live = (state_q != HOLD) && !bus.stall
                      && (bus.jr || bus.jump || bus.br_taken);

  always_comb begin
    if (bus.jr)        redir_raw = bus.jr_addr;
    else if (bus.jump) redir_raw = bus.j_addr;
    else               redir_raw = br_target;
  end

  assign redir_addr = {redir_raw[31:2], 2'b00};
  assign redir_mis  = |redir_raw[1:0];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    pend_addr_d  = pend_addr_q;
    pend_valid_d = pend_valid_q;
    pend_err_d   = pend_err_q;
    addr_err_d   = 1'b0;
    fetch_cnt_d  = fetch_cnt_q;

    unique case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   state_d = bus.stall ? HOLD : FETCH;
      HOLD:    state_d = bus.stall ? HOLD : FETCH;
      default: state_d = BOOT;
    endcase
    imem_req_d = (state_d == FETCH);

    if (accept) begin
      fetch_cnt_d  = fetch_cnt_q + CNT_W'(1);
      pend_valid_d = 1'b0;
      if (redir_live) begin
        pc_d       = redir_addr;
        addr_err_d = redir_mis;
      end else if (pend_valid_q) begin
        pc_d       = pend_addr_q;
        addr_err_d = pend_err_q;
      end else begin
        pc_d = pc_4;
      end
    end else if (redir_live) begin
      // Newest redirect wins; the alignment fault travels with it until it is taken.
      pend_valid_d = 1'b1;
      pend_addr_d  = redir_addr;
      pend_err_d   = redir_mis;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VEC;
      pend_addr_q  <= 32'd0;
      pend_valid_q <= 1'b0;
      pend_err_q   <= 1'b0;
      imem_req_q   <= 1'b0;
      addr_err_q   <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_addr_q  <= pend_addr_d;
      pend_valid_q <= pend_valid_d;
      pend_err_q   <= pend_err_d;
      imem_req_q   <= imem_req_d;
      addr_err_q   <= addr_err_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.imem_addr = pc_q;
  assign bus.pc_4      = pc_4;
  assign bus.imem_req  = imem_req_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Table-driven bench for pc_next_unit: expected post-edge state is queued when a
// vector is driven and popped for comparison one time unit after the edge.
module tb_pc_next_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_next_if #(.CNT_W(32)) bus ();

  pc_next_unit #(.RESET_VEC(32'h0000_0000), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        stall, gnt, jump, jr, br;
    logic [31:0] j_addr, jr_addr, br_off;
    logic [31:0] e_pc;
    logic        e_req, e_err;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        req, err;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic stall, gnt, jump, jr, br,
                              input logic [31:0] j_addr, jr_addr, br_off, e_pc,
                              input logic e_req, e_err, input logic [31:0] e_cnt);
    vec_t v;
    v.stall = stall; v.gnt = gnt; v.jump = jump; v.jr = jr; v.br = br;
    v.j_addr = j_addr; v.jr_addr = jr_addr; v.br_off = br_off;
    v.e_pc = e_pc; v.e_req = e_req; v.e_err = e_err; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.stall     = v.stall;
    bus.imem_gnt  = v.gnt;
    bus.jump      = v.jump;
    bus.jr        = v.jr;
    bus.br_taken  = v.br;
    bus.j_addr    = v.j_addr;
    bus.jr_addr   = v.jr_addr;
    bus.br_offset = v.br_off;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    logic [31:0] e_pc4;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    e_pc4 = e.pc + 32'd4;
    check({tag, " pc"},        bus.pc,                 e.pc);
    check({tag, " imem_addr"}, bus.imem_addr,          e.pc);
    check({tag, " pc_4"},      bus.pc_4,               e_pc4);
    check({tag, " imem_req"},  {31'd0, bus.imem_req},  {31'd0, e.req});
    check({tag, " addr_err"},  {31'd0, bus.addr_err},  {31'd0, e.err});
    check({tag, " fetch_cnt"}, bus.fetch_cnt,          e.cnt);
  endtask

  // Drive one vector, queue its expectation, clock once and compare just after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    drive(v);
    e.pc = v.e_pc; e.req = v.e_req; e.err = v.e_err; e.cnt = v.e_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  localparam logic [31:0] Z = 32'd0;
  vec_t vecs[25];

  initial begin
    //              stall gnt jmp jr br  j_addr         jr_addr        br_off         e_pc           req err cnt
    vecs[0]  = mk(0, 1, 0, 0, 0, Z,             Z,             Z,             32'h0000_0000, 1, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0, Z,             Z,             Z,             32'h0000_0004, 1, 0, 1);
    vecs[2]  = mk(0, 1, 0, 0, 0, Z,             Z,             Z,             32'h0000_0008, 1, 0, 2);
    vecs[3]  = mk(0, 1, 0, 0, 0, Z,             Z,             Z,             32'h0000_000C, 1, 0, 3);
    vecs[4]  = mk(0, 1, 0, 1, 0, Z,             32'h4000_0010, Z,             32'h4000_0010, 1, 0, 4);
    vecs[5]  = mk(0, 1, 1, 0, 0, 32'h4012_3450, Z,             Z,             32'h4012_3450, 1, 0, 5);
    vecs[6]  = mk(0, 1, 0, 1, 0, Z,             32'h0000_0100, Z,             32'h0000_0100, 1, 0, 6);
    vecs[7]  = mk(0, 1, 0, 0, 1, Z,             Z,             32'hFFFF_FFFE, 32'h0000_00FC, 1, 0, 7);
    vecs[8]  = mk(0, 1, 1, 1, 1, 32'h4012_3450, 32'h0000_0200, 32'h0000_0010, 32'h0000_0200, 1, 0, 8);
    vecs[9]  = mk(0, 0, 1, 0, 0, 32'h0000_0800, Z,             Z,             32'h0000_0200, 1, 0, 8);
    vecs[10] = mk(0, 0, 0, 0, 0, Z,             Z,             Z,             32'h0000_0200, 1, 0, 8);
    vecs[11] = mk(0, 0, 0, 0, 0, Z,             Z,             Z,             32'h0000_0200, 1, 0, 8);
    vecs[12] = mk(0, 1, 0, 0, 0, Z,             Z,             Z,             32'h0000_0800, 1, 0, 9);
    vecs[13] = mk(0, 1, 0, 1, 0, Z,             32'h0000_0020, Z,             32'h0000_0020, 1, 0, 10);
    vecs[14] = mk(1, 1, 0, 0, 0, Z,             Z,             Z,             32'h0000_0020, 0, 0, 10);
    vecs[15] = mk(1, 1, 0, 0, 0, Z,             Z,             Z,             32'h0000_0020, 0, 0, 10);
    vecs[16] = mk(0, 1, 0, 1, 0, Z,             32'h0000_0500, Z,             32'h0000_0020, 1, 0, 10);
    vecs[17] = mk(0, 1, 0, 0, 0, Z,             Z,             Z,             32'h0000_0024, 1, 0, 11);
    vecs[18] = mk(0, 1, 0, 1, 0, Z,             32'h0000_0103, Z,             32'h0000_0100, 1, 1, 12);
    vecs[19] = mk(0, 1, 0, 0, 0, Z,             Z,             Z,             32'h0000_0104, 1, 0, 13);
    vecs[20] = mk(0, 1, 0, 1, 0, Z,             32'hFFFF_FFFC, Z,             32'hFFFF_FFFC, 1, 0, 14);
    vecs[21] = mk(0, 1, 0, 0, 0, Z,             Z,             Z,             32'h0000_0000, 1, 0, 15);
    vecs[22] = mk(0, 0, 1, 0, 0, 32'h0000_0800, Z,             Z,             32'h0000_0000, 1, 0, 15);
    vecs[23] = mk(0, 0, 0, 1, 0, Z,             32'h0000_0300, Z,             32'h0000_0000, 1, 0, 15);
    vecs[24] = mk(0, 1, 0, 0, 0, Z,             Z,             Z,             32'h0000_0300, 1, 0, 16);

    drive(mk(0, 1, 0, 0, 0, Z, Z, Z, Z, 0, 0, 0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset pc",        bus.pc,                Z);
    check("reset imem_req",  {31'd0, bus.imem_req}, Z);
    check("reset addr_err",  {31'd0, bus.addr_err}, Z);
    check("reset fetch_cnt", bus.fetch_cnt,         Z);
    check("reset pc_4",      bus.pc_4,              32'h0000_0004);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      if (i == 5) check("pc_4 top nibble before jump", {28'd0, bus.pc_4[31:28]}, 32'h4);
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-wait: a pending jump must be lost and the fetch stream restart at RESET_VEC.
    apply(mk(0, 0, 1, 0, 0, 32'h0000_0800, Z, Z, 32'h0000_0300, 1, 0, 16), "wait jump");
    #2 rst_n = 1'b0;
    #1;
    check("midreset pc",        bus.pc,                Z);
    check("midreset imem_req",  {31'd0, bus.imem_req}, Z);
    check("midreset fetch_cnt", bus.fetch_cnt,         Z);
    drive(mk(0, 1, 0, 0, 0, Z, Z, Z, Z, 0, 0, 0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    apply(mk(0, 1, 0, 0, 0, Z, Z, Z, 32'h0000_0000, 1, 0, 0), "post reset boot");
    apply(mk(0, 1, 0, 0, 0, Z, Z, Z, 32'h0000_0004, 1, 0, 1), "post reset fetch");

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard drain: got %0d leftover expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
